// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: command FIFO feeding a combinational ALU, plus a registered
// result slot with its own valid/ready handshake. The FIFO head is driven
// straight from storage so the ALU result is ready within the same cycle.
module alu_cmd_queue #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [DATA_W-1:0]        cmd_a_i,
  input  logic [DATA_W-1:0]        cmd_b_i,
  input  logic [OP_W-1:0]          cmd_op_i,
  output logic [DATA_W-1:0]        alu_a_o,
  output logic [DATA_W-1:0]        alu_b_o,
  output logic [OP_W-1:0]          alu_op_o,
  input  logic [DATA_W-1:0]        alu_res_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [DATA_W-1:0]        res_data_o,
  output logic [OP_W-1:0]          res_op_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Command storage, one array per field
  logic [DATA_W-1:0] a_mem  [DEPTH];
  logic [DATA_W-1:0] b_mem  [DEPTH];
  logic [OP_W-1:0]   op_mem [DEPTH];

  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic [CW-1:0]     count_next;
  logic              res_valid_reg;
  logic [DATA_W-1:0] res_data_reg;
  logic [OP_W-1:0]   res_op_reg;

  logic              head_valid;
  logic              push;
  logic              issue;

  assign head_valid  = (count_reg != '0);
  // Ready depends on occupancy only: a full queue refuses a push even when
  // the head is being issued in the same cycle.
  assign cmd_ready_o = (count_reg < DEPTH_C);
  assign push        = cmd_valid_i & cmd_ready_o;
  assign issue       = head_valid & (~res_valid_reg | res_ready_i);

  assign count_o     = count_reg;
  assign res_valid_o = res_valid_reg;
  assign res_data_o  = res_data_reg;
  assign res_op_o    = res_op_reg;

  // Present the FIFO head to the ALU; zeros while the queue is empty
  always_comb begin
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_op_o = '0;
    if (head_valid) begin
      alu_a_o  = a_mem[rd_ptr_reg];
      alu_b_o  = b_mem[rd_ptr_reg];
      alu_op_o = op_mem[rd_ptr_reg];
    end
  end

  // Occupancy update: push and issue in the same cycle cancel out
  always_comb begin
    count_next = count_reg;
    case ({push, issue})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Command storage write; contents need no reset since count gates the head
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr_reg]  <= cmd_a_i;
      b_mem[wr_ptr_reg]  <= cmd_b_i;
      op_mem[wr_ptr_reg] <= cmd_op_i;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (issue) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
    end
  end

  // Result slot: capture the ALU output on issue, otherwise drain or hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_op_reg    <= '0;
    end else if (issue) begin
      res_valid_reg <= 1'b1;
      res_data_reg  <= alu_res_i;
      res_op_reg    <= op_mem[rd_ptr_reg];
    end else if (res_valid_reg && res_ready_i) begin
      res_valid_reg <= 1'b0;
    end
  end

endmodule

// File: doc/alu_cmd_queue.md
Name: alu_cmd_queue

Overview:
- Command/result stage wrapped around the 8-bit combinational ALU.
- Accepts operand/opcode commands over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Drives the FIFO head onto the ALU inputs, then registers the ALU result into an output slot with its own valid/ready handshake.
- Is the ALU's upstream feeder and its downstream result register in one block.

Parameters:
- DATA_W, 8, operand and result width; must match the ALU.
- OP_W, 3, opcode width; must match the ALU.
- DEPTH, 4, command FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- cmd_valid_i  input  1  command present.
- cmd_ready_o  output  1  queue can accept a command.
- cmd_a_i  input  DATA_W  operand A.
- cmd_b_i  input  DATA_W  operand B.
- cmd_op_i  input  OP_W  opcode.
- alu_a_o  output  DATA_W  operand A of the FIFO head, to the ALU.
- alu_b_o  output  DATA_W  operand B of the FIFO head, to the ALU.
- alu_op_o  output  OP_W  opcode of the FIFO head, to the ALU.
- alu_res_i  input  DATA_W  combinational ALU result for alu_a_o/alu_b_o/alu_op_o.
- res_valid_o  output  1  result slot holds a result.
- res_ready_i  input  1  consumer takes the result.
- res_data_o  output  DATA_W  registered ALU result.
- res_op_o  output  OP_W  opcode that produced res_data_o.
- count_o  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (reset_n). All state clears immediately on reset_n=0.
- Reset values:
  - FIFO pointers = 0, count_o = 0.
  - res_valid_o = 0, res_data_o = 0, res_op_o = 0.
  - cmd_ready_o = 1 (derived from count).
  - alu_a_o/alu_b_o/alu_op_o = 0.
- Push: cmd_valid_i & cmd_ready_o at a rising edge writes {a,b,op} at the write pointer, which increments modulo DEPTH.
- cmd_ready_o = (count_o < DEPTH):
  - combinational from the count only, never from same-cycle pop;
  - when full, no push occurs even if a pop happens in that cycle.
- Head drive:
  - when count_o > 0, alu_*_o show the entry at the read pointer, straight from storage;
  - when empty, alu_*_o = 0.
- Issue condition = (count_o > 0) & (!res_valid_o | res_ready_i). On an issuing edge:
  - res_data_o <= alu_res_i;
  - res_op_o <= head op;
  - res_valid_o <= 1;
  - read pointer increments modulo DEPTH.
- Drain without refill: res_valid_o & res_ready_i & count_o == 0 -> res_valid_o <= 0. res_data_o and res_op_o hold their last values.
- Hold: while res_valid_o & !res_ready_i, res_data_o and res_op_o stay stable and no issue occurs.
- Simultaneous push and issue: count_o unchanged, both pointers advance.
- Latency: a command accepted at edge k is at the head after k. If the slot is free or draining, res_valid_o = 1 with its result after edge k+1.
- Throughput: one result per cycle when the FIFO is non-empty and res_ready_i = 1.
- Ordering: results leave in command order; no loss, no duplication.
- Opcodes are not interpreted. Any OP_W value passes through; result correctness is the ALU's responsibility. No overflow or flags are handled here: width is DATA_W, wrap-around comes from the ALU.
- Reset mid-operation: queued commands and any pending result are discarded; no partial result appears after reset release.

Test Plan:
1. Single add: push a=8'h12, b=8'h34, op=3'b000 with res_ready_i=1 -> res_valid_o=1 one edge after acceptance, res_data_o=8'h46, res_op_o=3'b000. count_o returns to 0; res_valid_o falls on the next edge.
2. Wrap-around: push add 8'hF0+8'h20, then sub 8'h05-8'h07 back-to-back -> results 8'h10 then 8'hFE on consecutive cycles, in order.
3. Full/backpressure: res_ready_i=0, push 5 commands (and 8'hFF&8'h0F, op=3'b100, ...):
   - first lands in the result slot and res_data_o=8'h0F holds stable;
   - count_o=4 and cmd_ready_o=0; a 6th push is not accepted;
   - raise res_ready_i -> 5 results in order, count_o reaches 0.
4. Simultaneous push/issue at count_o=2 with res_ready_i=1 and cmd_valid_i=1 -> count_o stays 2 for each such cycle; pointers wrap past DEPTH-1 with correct data.
5. Full plus pop: count_o=4, res_valid_o=1, res_ready_i=1, cmd_valid_i=1 -> issue occurs, no push, count_o=3; push is accepted on the following edge.
6. Reset mid-operation: count_o=3 and res_valid_o=1, assert reset_n=0 between edges -> outputs immediately at reset values; after release no stale result and cmd_ready_o=1.
